// File: rtl/rhythm_pkg.sv
// Shared definitions for the rhythm recorder and the playback datapath that reads its map.
package rhythm_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNT_IN = 2'd1,
    RECORD   = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam int MAP_LEN_DEFAULT = 191;
  localparam int LEAD_IN_DEFAULT = 4;
endpackage

// File: rtl/key_press_sync.sv
// 2-FF synchroniser plus falling-edge detect for an active-low key; one-cycle press pulse
// two clocks after the key falls. Reset loads the released level so no press fires at release.
module key_press_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_press
);
  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_key_n;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_press = r_prev & ~r_sync;
endmodule

// File: rtl/rhythm_recorder.sv
// Records taps quantised to the beat grid into a map (bit 0 = first beat); all outputs are
// registered or decoded from the state register, so keys reach them only through the synchronisers.
module rhythm_recorder
  import rhythm_pkg::*;
#(
  parameter int MAP_LEN = MAP_LEN_DEFAULT,
  parameter int LEAD_IN = LEAD_IN_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               beat_tick,
  input  logic               start_n,
  input  logic               tap_n,
  output logic [MAP_LEN-1:0] rhythm_map,
  output logic [7:0]         map_len,
  output logic               map_valid,
  output logic               recording,
  output logic [3:0]         lead_count,
  output logic               tap_echo
);
  state_t             r_state;
  logic [MAP_LEN-1:0] r_map;
  logic [7:0]         r_map_len;
  logic [7:0]         r_wr_ptr;
  logic [3:0]         r_lead;
  logic               r_tap_pending;
  logic               r_tap_echo;

  logic w_start_press;
  logic w_tap_press;
  logic w_bit;

  key_press_sync u_start_sync (
    .clk     (clk),
    .rst     (rst),
    .i_key_n (start_n),
    .o_press (w_start_press)
  );

  key_press_sync u_tap_sync (
    .clk     (clk),
    .rst     (rst),
    .i_key_n (tap_n),
    .o_press (w_tap_press)
  );

  // A tap landing on the tick itself still belongs to the beat being committed.
  assign w_bit = r_tap_pending | w_tap_press;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_map         <= '0;
      r_map_len     <= 8'd0;
      r_wr_ptr      <= 8'd0;
      r_lead        <= 4'd0;
      r_tap_pending <= 1'b0;
      r_tap_echo    <= 1'b0;
    end else begin
      if (beat_tick) r_tap_echo <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_start_press) begin
            r_state       <= COUNT_IN;
            r_map         <= '0;
            r_map_len     <= 8'd0;
            r_wr_ptr      <= 8'd0;
            r_tap_pending <= 1'b0;
            r_tap_echo    <= 1'b0;
            r_lead        <= 4'(LEAD_IN);
          end
        end
        COUNT_IN: begin
          if (w_start_press) begin
            r_state <= IDLE;
            r_lead  <= 4'd0;
          end else if (beat_tick) begin
            r_lead <= r_lead - 4'd1;
            if (r_lead == 4'd1) r_state <= RECORD;
          end
        end
        RECORD: begin
          if (beat_tick) begin
            for (int i = 0; i < MAP_LEN; i++) begin
              if (r_wr_ptr == 8'(i)) r_map[i] <= w_bit;
            end
            r_tap_echo    <= w_bit;
            r_tap_pending <= 1'b0;
            r_map_len     <= r_wr_ptr + 8'd1;
            if (r_wr_ptr == 8'(MAP_LEN - 1)) r_state <= DONE;
            else                             r_wr_ptr <= r_wr_ptr + 8'd1;
          end else if (w_tap_press) begin
            r_tap_pending <= 1'b1;
          end
          // Stop wins over a pending tap; a coincident tick has already committed above.
          if (w_start_press) begin
            r_state       <= DONE;
            r_tap_pending <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rhythm_map = r_map;
  assign map_len    = r_map_len;
  assign map_valid  = (r_state == DONE);
  assign recording  = (r_state == COUNT_IN) || (r_state == RECORD);
  assign lead_count = r_lead;
  assign tap_echo   = r_tap_echo;
endmodule

// File: tb/tb_rhythm_recorder.sv
// Directed bench: default-size recorder plus a small (MAP_LEN=8, LEAD_IN=1) instance.
module tb_rhythm_recorder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bt = 1'b0;
  logic sn = 1'b1;
  logic tn = 1'b1;
  logic sel8 = 1'b0;

  logic [190:0] map_a;
  logic [7:0]   len_a;
  logic         valid_a, rec_a, echo_a;
  logic [3:0]   lead_a;

  logic [7:0]   map_b;
  logic [7:0]   len_b;
  logic         valid_b, rec_b, echo_b;
  logic [3:0]   lead_b;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rhythm_recorder dut (
    .clk        (clk),
    .rst        (rst),
    .beat_tick  (sel8 ? 1'b0 : bt),
    .start_n    (sel8 ? 1'b1 : sn),
    .tap_n      (sel8 ? 1'b1 : tn),
    .rhythm_map (map_a),
    .map_len    (len_a),
    .map_valid  (valid_a),
    .recording  (rec_a),
    .lead_count (lead_a),
    .tap_echo   (echo_a)
  );

  rhythm_recorder #(.MAP_LEN(8), .LEAD_IN(1)) dut8 (
    .clk        (clk),
    .rst        (rst),
    .beat_tick  (sel8 ? bt : 1'b0),
    .start_n    (sel8 ? sn : 1'b1),
    .tap_n      (sel8 ? tn : 1'b1),
    .rhythm_map (map_b),
    .map_len    (len_b),
    .map_valid  (valid_b),
    .recording  (rec_b),
    .lead_count (lead_b),
    .tap_echo   (echo_b)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick();
    bt = 1'b1; cyc(1); bt = 1'b0;
  endtask

  task automatic tap();
    tn = 1'b0; cyc(3); tn = 1'b1; cyc(3);
  endtask

  task automatic start();
    sn = 1'b0; cyc(3); sn = 1'b1; cyc(3);
  endtask

  // Key pulse reaches the FSM on the third edge; align the tick with that edge.
  task automatic tap_tick();
    tn = 1'b0; cyc(2); bt = 1'b1; cyc(1); bt = 1'b0; tn = 1'b1; cyc(3);
  endtask

  task automatic start_tick();
    sn = 1'b0; cyc(2); bt = 1'b1; cyc(1); bt = 1'b0; sn = 1'b1; cyc(3);
  endtask

  initial begin
    cyc(3);
    chk("rst_map",   map_a,   0);
    chk("rst_len",   len_a,   0);
    chk("rst_valid", valid_a, 0);
    chk("rst_rec",   rec_a,   0);
    chk("rst_lead",  lead_a,  0);
    chk("rst_echo",  echo_a,  0);
    rst = 1'b1; cyc(2);

    // Ticks with no keys leave the recorder idle.
    repeat (10) tick();
    cyc(2);
    chk("idle_map",   map_a,   0);
    chk("idle_len",   len_a,   0);
    chk("idle_valid", valid_a, 0);
    chk("idle_rec",   rec_a,   0);

    // Count-in.
    start();
    chk("ci_rec",   rec_a,  1);
    chk("ci_lead4", lead_a, 4);
    tap();
    tick(); cyc(1); chk("ci_lead3", lead_a, 3);
    tick(); cyc(1); chk("ci_lead2", lead_a, 2);
    tick(); cyc(1); chk("ci_lead1", lead_a, 1);
    chk("ci_rec1", rec_a, 1);
    tap();
    tick(); cyc(1); chk("ci_lead0", lead_a, 0);
    chk("rec_entered", rec_a, 1);
    chk("ci_map0", map_a, 0);

    // Taps on beats 0, 2 (twice) and 5, stop after beat 7.
    tap(); tick(); cyc(1);
    chk("echo_b0", echo_a, 1);
    chk("len_b0",  len_a,  1);
    tick(); cyc(1); chk("echo_b1", echo_a, 0);
    tap(); tap(); tick(); cyc(1); chk("echo_b2", echo_a, 1);
    tick(); tick();
    tap(); tick(); cyc(1); chk("echo_b5", echo_a, 1);
    tick(); tick(); cyc(1);
    start();
    chk("t3_map",   map_a,   8'b0010_0101);
    chk("t3_len",   len_a,   8);
    chk("t3_valid", valid_a, 1);
    chk("t3_rec",   rec_a,   0);
    tap(); tick(); cyc(1);
    chk("done_frozen_map", map_a, 8'b0010_0101);
    chk("done_frozen_len", len_a, 8);

    // Re-record: coincident tap at slot 3, coincident stop at slot 6.
    start();
    chk("rr_map0",  map_a,   0);
    chk("rr_len0",  len_a,   0);
    chk("rr_valid", valid_a, 0);
    chk("rr_lead",  lead_a,  4);
    repeat (4) tick();
    tick(); tick(); tick();
    tap_tick();
    chk("t4_echo3", echo_a, 1);
    chk("t4_len4",  len_a,  4);
    tick(); tick();
    start_tick();
    chk("t4_map",   map_a,   8'b0000_1000);
    chk("t4_len",   len_a,   7);
    chk("t4_valid", valid_a, 1);

    // Small instance: fill every slot, auto-DONE on the eighth tick.
    sel8 = 1'b1; cyc(1);
    start();
    chk("s_lead1", lead_b, 1);
    tick(); cyc(1);
    chk("s_rec", rec_b, 1);
    repeat (7) begin tap(); tick(); end
    cyc(1);
    chk("s_len7",   len_b,   7);
    chk("s_valid7", valid_b, 0);
    tap(); tick(); cyc(1);
    chk("s_map",   map_b,   8'hFF);
    chk("s_len",   len_b,   8);
    chk("s_valid", valid_b, 1);
    chk("s_rec0",  rec_b,   0);
    tap(); tick(); tap(); tick(); cyc(1);
    chk("s_map_hold", map_b, 8'hFF);
    chk("s_len_hold", len_b, 8);

    // Reset in the middle of a take.
    sel8 = 1'b0; cyc(1);
    start();
    repeat (4) tick();
    tap(); tick(); tick(); tap(); tick(); cyc(1);
    chk("mid_len3", len_a, 3);
    chk("mid_map",  map_a, 8'b0000_0101);
    rst = 1'b0; cyc(1);
    chk("mr_map",   map_a,   0);
    chk("mr_len",   len_a,   0);
    chk("mr_valid", valid_a, 0);
    chk("mr_rec",   rec_a,   0);
    chk("mr_lead",  lead_a,  0);
    chk("mr_echo",  echo_a,  0);
    rst = 1'b1; cyc(2);
    start();
    chk("fresh_rec",  rec_a,  1);
    chk("fresh_lead", lead_a, 4);
    chk("fresh_map",  map_a,  0);
    chk("fresh_len",  len_a,  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
